e_mdu: RTL and testbench

- Execute-stage multiply/divide unit.
- Consumes the E-pipelined `start` qualifier and E-stage opcode/funct that the decode controller produces for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Owns the HI/LO registers and models the multi-cycle latency with a countdown and busy flag.
- Exports `E_MDU_busy` so the hazard unit can stall D-stage MDU instructions.

---
 rtl/e_mdu.sv | 137 +++++++++++++
 tb/tb_e_mdu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency
// with a countdown; results are held in shadow registers until the commit edge.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_fuc,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDU_busy,
  output logic        E_MDU_stall_cond,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          keep;
  logic [31:0]   hi, lo, sh_hi, sh_lo;

  logic        is_mdu, do_mult, do_div, do_mthi, do_mtlo, do_mfhi, do_mflo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, udiv, sdiv, q_u, r_u, mag_q, mag_r, q_s, r_s;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    is_mdu  = E_start && (E_op == 6'b000000);
    do_mult = is_mdu && (E_fuc == F_MULT || E_fuc == F_MULTU);
    do_div  = is_mdu && (E_fuc == F_DIV  || E_fuc == F_DIVU);
    do_mthi = is_mdu && (E_fuc == F_MTHI);
    do_mtlo = is_mdu && (E_fuc == F_MTLO);
    do_mfhi = is_mdu && (E_fuc == F_MFHI);
    do_mflo = is_mdu && (E_fuc == F_MFLO);
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on tool behaviour for signed overflow.
  always_comb begin
    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'b0, E_A} * {32'b0, E_B};
    abs_a  = E_A[31] ? (~E_A + 32'd1) : E_A;
    abs_b  = E_B[31] ? (~E_B + 32'd1) : E_B;
    udiv   = (E_B == '0) ? 32'd1 : E_B;
    sdiv   = (abs_b == '0) ? 32'd1 : abs_b;
    q_u    = E_A / udiv;
    r_u    = E_A % udiv;
    mag_q  = abs_a / sdiv;
    mag_r  = abs_a % sdiv;
    q_s    = (E_A[31] ^ E_B[31]) ? (~mag_q + 32'd1) : mag_q;
    r_s    = E_A[31] ? (~mag_r + 32'd1) : mag_r;
    res_hi = '0;
    res_lo = '0;
    case (E_fuc)
      F_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      F_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      F_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      F_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      keep  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
    end else begin
      if (do_mthi) hi <= E_A;
      if (do_mtlo) lo <= E_A;
      case (state)
        IDLE: begin
          if (do_mult || do_div) begin
            sh_hi <= res_hi;
            sh_lo <= res_lo;
            keep  <= do_div && (E_B == '0);
            cnt   <= do_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          // Commit is placed after the mthi/mtlo writes so it wins on the same edge.
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!keep) begin
              hi <= sh_hi;
              lo <= sh_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    E_MDU_out = '0;
    if (do_mfhi)      E_MDU_out = hi;
    else if (do_mflo) E_MDU_out = lo;
  end

  assign E_MDU_busy       = busy;
  assign E_MDU_stall_cond = E_start | busy;
  assign E_HI             = hi;
  assign E_LO             = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against an arithmetic HI/LO model.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [5:0]  E_op, E_fuc;
  logic [31:0] E_A, E_B;
  logic        E_MDU_busy, E_MDU_stall_cond;
  logic [31:0] E_HI, E_LO, E_MDU_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_op(E_op), .E_fuc(E_fuc),
    .E_A(E_A), .E_B(E_B), .E_MDU_busy(E_MDU_busy), .E_MDU_stall_cond(E_MDU_stall_cond),
    .E_HI(E_HI), .E_LO(E_LO), .E_MDU_out(E_MDU_out)
  );

  function automatic void model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      F_MULT:  begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      F_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      F_DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      F_DIVU:  if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
      F_MTHI:  m_hi = a;
      F_MTLO:  m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] f);
    if (f == F_MULT || f == F_MULTU) return MC;
    if (f == F_DIV || f == F_DIVU) return DC;
    return 0;
  endfunction

  // Called at a negedge; returns at the first negedge with busy low after the op.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    logic stall_ok;
    E_start = 1'b1; E_op = 6'b000000; E_fuc = f; E_A = a; E_B = b;
    #1;
    checks++;
    if (E_MDU_stall_cond !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_at_start: got %b expected 1", name, E_MDU_stall_cond);
    end
    @(negedge clk);
    E_start = 1'b0; E_A = $urandom; E_B = $urandom;
    model_op(f, a, b);
    n = 0;
    stall_ok = 1'b1;
    while (E_MDU_busy === 1'b1 && n < 64) begin
      n++;
      if (E_MDU_stall_cond !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n !== latency(f)) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, latency(f));
    end
    if (n > 0) begin
      checks++;
      if (stall_ok !== 1'b1) begin
        errors++;
        $display("FAIL %s stall_while_busy: got 0 expected 1 on every busy cycle", name);
      end
    end
    checks++;
    if (E_HI !== m_hi) begin
      errors++;
      $display("FAIL %s HI: got %h expected %h", name, E_HI, m_hi);
    end
    checks++;
    if (E_LO !== m_lo) begin
      errors++;
      $display("FAIL %s LO: got %h expected %h", name, E_LO, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; E_start = 1'b0; E_op = '0; E_fuc = '0; E_A = '0; E_B = '0;
    #1 reset = 1'b0;
    #2;
    m_hi = '0; m_lo = '0;
    checks++;
    if ({E_MDU_busy, E_MDU_stall_cond} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: got %b%b expected 00", E_MDU_busy, E_MDU_stall_cond);
    end
    checks++;
    if (E_HI !== m_hi || E_LO !== m_lo) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h expected %h/%h", E_HI, E_LO, m_hi, m_lo);
    end
    E_start = 1'b1; E_fuc = F_MFHI;
    #1;
    checks++;
    if (E_MDU_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got %h expected 00000000", E_MDU_out);
    end
    E_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op(F_MULT,  32'hFFFFFFFE, 32'd3, "mult_neg2x3");
    run_op(F_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
    run_op(F_DIV,   32'hFFFFFFF9, 32'd2, "div_neg7_2");
    run_op(F_DIVU,  32'd7,        32'd2, "divu_7_2");
    run_op(F_MTHI,  32'h11,       32'd0, "mthi_11");
    run_op(F_MTLO,  32'h22,       32'd0, "mtlo_22");
    run_op(F_DIVU,  32'd5,        32'd0, "divu_by_zero");
    run_op(F_DIV,   32'h12345678, 32'd0, "div_by_zero");
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, "div_overflow");
  endtask

  task automatic test_move_from;
    run_op(F_MTHI, 32'hDEADBEEF, 32'd0, "mthi_deadbeef");
    E_start = 1'b1; E_op = 6'b000000; E_fuc = F_MFHI;
    #1;
    checks++;
    if (E_MDU_out !== m_hi) begin
      errors++;
      $display("FAIL mfhi_out: got %h expected %h", E_MDU_out, m_hi);
    end
    E_fuc = F_MFLO;
    #1;
    checks++;
    if (E_MDU_out !== m_lo) begin
      errors++;
      $display("FAIL mflo_out: got %h expected %h", E_MDU_out, m_lo);
    end
    E_start = 1'b0; E_op = 6'b100011; E_fuc = F_MFHI;
    #1;
    checks++;
    if (E_MDU_out !== 32'h0) begin
      errors++;
      $display("FAIL non_mdu_out: got %h expected 00000000", E_MDU_out);
    end
    E_start = 1'b1; E_op = 6'b100011;
    #1;
    checks++;
    if (E_MDU_out !== 32'h0) begin
      errors++;
      $display("FAIL nonzero_op_out: got %h expected 00000000", E_MDU_out);
    end
    E_op = 6'b000000; E_fuc = 6'b100001; E_A = 32'hCAFEF00D;
    #1;
    checks++;
    if (E_MDU_out !== 32'h0) begin
      errors++;
      $display("FAIL unknown_funct_out: got %h expected 00000000", E_MDU_out);
    end
    @(negedge clk);
    E_start = 1'b0;
    checks++;
    if (E_HI !== m_hi || E_LO !== m_lo || E_MDU_busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown_funct_state: got %h/%h busy %b expected %h/%h busy 0",
               E_HI, E_LO, E_MDU_busy, m_hi, m_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    run_op(F_MTHI, 32'hA5A5A5A5, 32'd0, "mthi_pre_reset");
    E_start = 1'b1; E_op = 6'b000000; E_fuc = F_MULT; E_A = 32'h7; E_B = 32'h9;
    @(negedge clk);
    E_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++;
    if (E_MDU_busy !== 1'b0 || E_HI !== m_hi || E_LO !== m_lo) begin
      errors++;
      $display("FAIL reset_mid_run: got busy %b %h/%h expected busy 0 %h/%h",
               E_MDU_busy, E_HI, E_LO, m_hi, m_lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) @(negedge clk);
    checks++;
    if (E_MDU_busy !== 1'b0 || E_HI !== m_hi || E_LO !== m_lo) begin
      errors++;
      $display("FAIL no_commit_after_reset: got busy %b %h/%h expected busy 0 %h/%h",
               E_MDU_busy, E_HI, E_LO, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    run_op(F_MULT, 32'h00012345, 32'hFFFF0001, "b2b_mult");
    run_op(F_DIV,  32'h87654321, 32'h00000123, "b2b_div");
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_multu");
  endtask

  task automatic test_random;
    logic [5:0] ops [6];
    logic [31:0] a, b;
    logic [5:0] f;
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV;
    ops[3] = F_DIVU; ops[4] = F_MTHI;  ops[5] = F_MTLO;
    for (int i = 0; i < 30; i++) begin
      f = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(f, a, b, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_move_from;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
